// File: rtl/sweep_freq_gen.sv
// sweep_freq_gen: steps the FFT bin index on next_freq rising edges and drives a DDS
// phase accumulator. Build option PHASE_RESET_EN restarts each tone at phase 0.
module sweep_freq_gen #(
    parameter logic [15:0] FREQ_START  = 16'd1,
    parameter logic [15:0] FREQ_STEP   = 16'd1,
    parameter logic [15:0] FREQ_MAX    = 16'd2751,
    parameter logic [31:0] INC_PER_BIN = 32'd1048576,
    parameter logic [31:0] STB_INC     = 32'd140737488
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        learn_en,
    input  logic        next_freq,
    output logic [15:0] freq,
    output logic        freq_chg,
    output logic [31:0] phase_inc,
    output logic        sample_stb,
    output logic [31:0] phase_out,
    output logic        sweep_done
);

    // state | meaning
    // IDLE  | sweep off, freq/phase held at 0
    // ARM   | load first bin on the next edge
    // RUN   | advance one bin per next_freq rising edge
    // DONE  | last bin reached, hold until learn_en drops
    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_ARM  = 4'b0010;
    localparam logic [3:0] ST_RUN  = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [15:0] freq_nxt;
    logic        freq_load;
    logic        nf_d;
    logic        rise;
    logic [16:0] step_sum;
    logic [15:0] step_sat;
    logic [15:0] start_sat;
    logic [31:0] stb_acc;
    logic [32:0] stb_sum;

    // 17-bit sum so the saturation compare sees a carry instead of a wrapped index
    assign step_sum  = {1'b0, freq} + {1'b0, FREQ_STEP};
    assign step_sat  = (step_sum >= {1'b0, FREQ_MAX}) ? FREQ_MAX : step_sum[15:0];
    assign start_sat = (FREQ_START >= FREQ_MAX) ? FREQ_MAX : FREQ_START;
    assign stb_sum   = {1'b0, stb_acc} + {1'b0, STB_INC};

    assign sweep_done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        freq_nxt  = freq;
        freq_load = 1'b0;
        if (!learn_en) begin
            state_nxt = ST_IDLE;
            freq_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_ARM;
                ST_ARM: begin
                    freq_nxt  = start_sat;
                    freq_load = 1'b1;
                    state_nxt = (start_sat == FREQ_MAX) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (rise && (freq != FREQ_MAX)) begin
                        freq_nxt  = step_sat;
                        freq_load = 1'b1;
                        if (step_sat == FREQ_MAX) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_nxt = ST_DONE;
                default: begin
                    state_nxt = ST_IDLE;
                    freq_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= ST_IDLE;
            nf_d      <= 1'b0;
            rise      <= 1'b0;
            freq      <= '0;
            freq_chg  <= 1'b0;
            phase_inc <= '0;
        end else begin
            nf_d      <= next_freq;
            rise      <= next_freq & ~nf_d;
            state     <= state_nxt;
            freq      <= freq_nxt;
            freq_chg  <= freq_load;
            // 16x32 multiply kept to the low 32 bits; cleared together with freq on sweep exit
            phase_inc <= learn_en ? ({16'd0, freq} * INC_PER_BIN) : '0;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            stb_acc    <= '0;
            sample_stb <= 1'b0;
        end else begin
            stb_acc    <= stb_sum[31:0];
            sample_stb <= stb_sum[32];
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            phase_out <= '0;
        end else if ((state == ST_IDLE) || !learn_en) begin
            phase_out <= '0;
`ifdef PHASE_RESET_EN
        end else if (freq_load) begin
            phase_out <= '0;
`endif
        end else if (sample_stb) begin
            phase_out <= phase_out + phase_inc;
        end
    end

endmodule
